// File: rtl/motion_pkg.sv
// Shared encodings for the motion command path: op codes, per-motor
// direction codes and the op -> direction-pair mapping.
package motion_pkg;

  localparam logic [2:0] OP_STOP  = 3'd0;
  localparam logic [2:0] OP_FWD   = 3'd1;
  localparam logic [2:0] OP_BACK  = 3'd2;
  localparam logic [2:0] OP_LEFT  = 3'd3;
  localparam logic [2:0] OP_RIGHT = 3'd4;

  localparam logic [1:0] DIR_HOLD = 2'd0;
  localparam logic [1:0] DIR_FWD  = 2'd1;
  localparam logic [1:0] DIR_REV  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [1:0] m1;
    logic [1:0] m2;
  } dir_pair_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_RIGHT);
  endfunction

  // Motor 2 is mirror-mounted, so "forward" for the vehicle is reverse on it.
  function automatic dir_pair_t op_to_dirs(input logic [2:0] op);
    dir_pair_t d;
    case (op)
      OP_FWD:   d = '{m1: DIR_FWD, m2: DIR_REV};
      OP_BACK:  d = '{m1: DIR_REV, m2: DIR_FWD};
      OP_LEFT:  d = '{m1: DIR_REV, m2: DIR_REV};
      OP_RIGHT: d = '{m1: DIR_FWD, m2: DIR_FWD};
      default:  d = '{m1: DIR_HOLD, m2: DIR_HOLD};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command handshake bundle between the SoC side and the motion sequencer.
interface motion_cmd_if #(parameter int STEP_W = 16);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_op, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/motion_sequencer_step_timer.sv
// Down-counter with load strobe; tc is high while the count sits at zero.
// Loading N-1 gives a tc after exactly N cycles.
module step_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/motion_sequencer.sv
// Motion command sequencer: accepts one command, drives the two motor
// direction codes for steps x STEP_PERIOD clocks, then forces a stopped
// settle gap before accepting the next command.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | codes 0/0, cmd_ready high, waiting for a command
//   ST_RUN    | codes driven, one half-step per STEP_PERIOD clocks
//   ST_SETTLE | codes 0/0 for SETTLE_CYC clocks, then done pulse
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int STEP_PERIOD = 100001,
  parameter int SETTLE_CYC  = 50000,
  parameter int STEP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  motion_cmd_if.slave       cmd,
  input  logic              abort,
  output logic [1:0]        direccion,
  output logic [1:0]        direccion2,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps_left
);

  // One timer serves both the half-step period and the settle gap, so it
  // is sized for whichever is longer.
  localparam int TW_RAW = (STEP_PERIOD > SETTLE_CYC) ? $clog2(STEP_PERIOD) : $clog2(SETTLE_CYC);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam logic [TW-1:0] PERIOD_LD = TW'(STEP_PERIOD - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

  seq_state_e      state;
  logic            ready_q;
  logic            accept;
  logic            go_run;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_tc;
  dir_pair_t       new_dirs;

  assign cmd.cmd_ready = ready_q;
  assign accept   = cmd.cmd_valid && ready_q;
  assign go_run   = (cmd.cmd_op != OP_STOP) && (cmd.cmd_steps != '0);
  assign new_dirs = op_to_dirs(cmd.cmd_op);

  // Timer reload decisions, aligned with the state transitions below.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PERIOD_LD;
    case (state)
      ST_IDLE: begin
        if (accept && op_legal(cmd.cmd_op)) begin
          tmr_load = 1'b1;
          tmr_val  = go_run ? PERIOD_LD : SETTLE_LD;
        end
      end
      ST_RUN: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end else if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = (steps_left == STEP_W'(1)) ? SETTLE_LD : PERIOD_LD;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = PERIOD_LD;
      end
    endcase
  end

  step_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Sequencing FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      direccion  <= DIR_HOLD;
      direccion2 <= DIR_HOLD;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!op_legal(cmd.cmd_op)) begin
              err <= 1'b1;
            end else if (go_run) begin
              state      <= ST_RUN;
              ready_q    <= 1'b0;
              busy       <= 1'b1;
              direccion  <= new_dirs.m1;
              direccion2 <= new_dirs.m2;
              steps_left <= cmd.cmd_steps;
            end else begin
              state   <= ST_SETTLE;
              ready_q <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state      <= ST_SETTLE;
            direccion  <= DIR_HOLD;
            direccion2 <= DIR_HOLD;
            steps_left <= '0;
          end else if (tmr_tc && steps_left != '0) begin
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state      <= ST_SETTLE;
              direccion  <= DIR_HOLD;
              direccion2 <= DIR_HOLD;
            end
          end
        end
        ST_SETTLE: begin
          direccion  <= DIR_HOLD;
          direccion2 <= DIR_HOLD;
          if (!abort && tmr_tc) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          ready_q    <= 1'b1;
          busy       <= 1'b0;
          direccion  <= DIR_HOLD;
          direccion2 <= DIR_HOLD;
          steps_left <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with STEP_PERIOD=4, SETTLE_CYC=3.
// Sample index i counts cycles after the accepting edge (i=1 is the first
// cycle the command is registered).
module tb_motion_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [1:0]  direccion;
  logic [1:0]  direccion2;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] steps_left;

  int errors = 0;
  int checks = 0;

  motion_cmd_if #(.STEP_W(16)) cif ();

  motion_sequencer #(
    .STEP_PERIOD (4),
    .SETTLE_CYC  (3),
    .STEP_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cif),
    .abort      (abort),
    .direccion  (direccion),
    .direccion2 (direccion2),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for exactly one edge, then withdraw it.
  task automatic accept(input logic [2:0] op, input logic [15:0] n);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_steps = n;
    step();
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'd0;
    cif.cmd_steps = 16'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 0, 32'(cif.cmd_ready), 32'd1);
    chk({tag, "_codes"}, 0, 32'({direccion, direccion2}), 32'd0);
    chk({tag, "_busy"},  0, 32'(busy), 32'd0);
    chk({tag, "_done"},  0, 32'(done), 32'd0);
    chk({tag, "_err"},   0, 32'(err), 32'd0);
    chk({tag, "_steps"}, 0, 32'(steps_left), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'd0;
    cif.cmd_steps = 16'd0;
    step();
    step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // FWD x3: {1,2} for 12 cycles, settle 3, done on cycle 16.
    accept(3'd1, 16'd3);
    for (int i = 1; i <= 16; i++) begin
      chk("fwd_codes", i, 32'({direccion, direccion2}), (i <= 12) ? 32'h6 : 32'h0);
      chk("fwd_steps", i, 32'(steps_left), (i <= 4) ? 32'd3 : (i <= 8) ? 32'd2 : (i <= 12) ? 32'd1 : 32'd0);
      chk("fwd_done",  i, 32'(done), (i == 16) ? 32'd1 : 32'd0);
      chk("fwd_ready", i, 32'(cif.cmd_ready), (i == 16) ? 32'd1 : 32'd0);
      chk("fwd_busy",  i, 32'(busy), (i == 16) ? 32'd0 : 32'd1);
      if (i < 16) step();
    end
    step();

    // LEFT x2 then RIGHT x1 held on the bus; RIGHT lands on the LEFT done cycle.
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 3'd3;
    cif.cmd_steps = 16'd2;
    step();
    cif.cmd_op    = 3'd4;
    cif.cmd_steps = 16'd1;
    for (int i = 1; i <= 20; i++) begin
      chk("lr_codes", i, 32'({direccion, direccion2}),
          (i <= 8) ? 32'hA : (i <= 12) ? 32'h0 : (i <= 16) ? 32'h5 : 32'h0);
      chk("lr_done",  i, 32'(done), (i == 12 || i == 20) ? 32'd1 : 32'd0);
      chk("lr_ready", i, 32'(cif.cmd_ready), (i == 12 || i == 20) ? 32'd1 : 32'd0);
      if (i == 13) begin
        chk("lr_steps", i, 32'(steps_left), 32'd1);
        cif.cmd_valid = 1'b0;
      end
      if (i < 20) step();
    end
    step();

    // BACK x10 aborted on cycle 5.
    accept(3'd2, 16'd10);
    for (int i = 1; i <= 9; i++) begin
      chk("ab_codes", i, 32'({direccion, direccion2}), (i <= 5) ? 32'h9 : 32'h0);
      chk("ab_steps", i, 32'(steps_left), (i <= 4) ? 32'd10 : (i == 5) ? 32'd9 : 32'd0);
      chk("ab_done",  i, 32'(done), (i == 9) ? 32'd1 : 32'd0);
      chk("ab_busy",  i, 32'(busy), (i == 9) ? 32'd0 : 32'd1);
      abort = (i == 5);
      if (i < 9) step();
    end
    abort = 1'b0;
    step();

    // Zero-step FWD, then STOP x7: settle only, never a non-zero code.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) accept(3'd1, 16'd0);
      else        accept(3'd0, 16'd7);
      for (int i = 1; i <= 4; i++) begin
        chk("z_codes", i, 32'({direccion, direccion2}), 32'h0);
        chk("z_steps", i, 32'(steps_left), 32'd0);
        chk("z_done",  i, 32'(done), (i == 4) ? 32'd1 : 32'd0);
        chk("z_busy",  i, 32'(busy), (i == 4) ? 32'd0 : 32'd1);
        if (i < 4) step();
      end
      step();
    end

    // Illegal op 6: single err pulse, stays idle.
    accept(3'd6, 16'd5);
    for (int i = 1; i <= 4; i++) begin
      chk("il_err",   i, 32'(err), (i == 1) ? 32'd1 : 32'd0);
      chk("il_busy",  i, 32'(busy), 32'd0);
      chk("il_codes", i, 32'({direccion, direccion2}), 32'h0);
      chk("il_done",  i, 32'(done), 32'd0);
      chk("il_ready", i, 32'(cif.cmd_ready), 32'd1);
      step();
    end

    // abort while idle does nothing.
    abort = 1'b1;
    step();
    step();
    chk("idle_abort_busy",  0, 32'(busy), 32'd0);
    chk("idle_abort_ready", 0, 32'(cif.cmd_ready), 32'd1);
    chk("idle_abort_done",  0, 32'(done), 32'd0);
    abort = 1'b0;
    step();

    // Reset during FWD x100, then an immediate BACK x2.
    accept(3'd1, 16'd100);
    for (int i = 1; i <= 6; i++) begin
      chk("rr_codes", i, 32'({direccion, direccion2}), 32'h6);
      step();
    end
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    accept(3'd2, 16'd2);
    for (int i = 1; i <= 12; i++) begin
      chk("pr_codes", i, 32'({direccion, direccion2}), (i <= 8) ? 32'h9 : 32'h0);
      chk("pr_done",  i, 32'(done), (i == 12) ? 32'd1 : 32'd0);
      if (i == 1) chk("pr_steps", i, 32'(steps_left), 32'd2);
      if (i < 12) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
